// File: rtl/barrel_rshift32_pipe_pkg.sv
// Shared widths and the per-stage record carried down the shifter pipeline.
package barrel_rshift32_pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int AMT_W   = 5;
  localparam int NSTAGES = 5;

  // Remaining amount bits are kept MSB-aligned: each stage consumes amt[AMT_W-1].
  typedef struct packed {
    logic              valid;
    logic              arith;
    logic [AMT_W-1:0]  amt;
    logic [DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/barrel_rshift32_pipe_if.sv
// Operand/result bundle for the pipelined right shifter, plus the freeze control.
interface barrel_rshift32_pipe_if;
  import barrel_rshift32_pipe_pkg::*;

  logic              hold;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amt;
  logic              in_arith;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output hold, in_valid, in_data, in_amt, in_arith,
    input  out_valid, out_data
  );

  modport slave (
    input  hold, in_valid, in_data, in_amt, in_arith,
    output out_valid, out_data
  );

endinterface

// File: rtl/barrel_rshift32_pipe_rshift_stage.sv
// One shifter stage: conditional right shift by K plus its pipeline register.
module rshift_stage
  import barrel_rshift32_pipe_pkg::*;
#(
  parameter int K = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  stage_t stage_in,
  output stage_t stage_out
);

  stage_t            stage_reg;
  stage_t            stage_next;
  logic [DATA_W-1:0] shifted;
  logic              fill_bit;

  // Earlier stages already replicated the sign, so bit 31 still equals the original MSB.
  assign fill_bit = stage_in.data[DATA_W-1] & stage_in.arith;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit
      if (gi < DATA_W - K) begin : g_take
        assign shifted[gi] = stage_in.data[gi+K];
      end else begin : g_fill
        assign shifted[gi] = fill_bit;
      end
    end
  endgenerate

  always_comb begin
    stage_next     = stage_in;
    stage_next.amt = {stage_in.amt[AMT_W-2:0], 1'b0};
    if (stage_in.amt[AMT_W-1]) begin
      stage_next.data = shifted;
    end
  end

  // Data is gated by hold only; contents of bubble slots are don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else if (!hold) begin
      stage_reg <= stage_next;
    end
  end

  assign stage_out = stage_reg;

endmodule

// File: rtl/barrel_rshift32_pipe.sv
// Five-stage pipelined 32-bit logical/arithmetic right shifter (shift by 16, 8, 4, 2, 1).
module barrel_rshift32_pipe
  import barrel_rshift32_pipe_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  barrel_rshift32_pipe_if.slave bus
);

  stage_t stage_head;
  stage_t stage_chain [NSTAGES];
  logic   unused_tail;

  always_comb begin
    stage_head       = '0;
    stage_head.valid = bus.in_valid;
    stage_head.arith = bus.in_arith;
    stage_head.amt   = bus.in_amt;
    stage_head.data  = bus.in_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        rshift_stage #(.K(DATA_W >> (gi + 1))) u_stage (
          .clk       (clk),
          .rst_n     (rst_n),
          .hold      (bus.hold),
          .stage_in  (stage_head),
          .stage_out (stage_chain[gi])
        );
      end else begin : g_next
        rshift_stage #(.K(DATA_W >> (gi + 1))) u_stage (
          .clk       (clk),
          .rst_n     (rst_n),
          .hold      (bus.hold),
          .stage_in  (stage_chain[gi-1]),
          .stage_out (stage_chain[gi])
        );
      end
    end
  endgenerate

  assign bus.out_valid = stage_chain[NSTAGES-1].valid;
  assign bus.out_data  = stage_chain[NSTAGES-1].data;

  // All amount bits are consumed by the last stage; the tail flags have no consumer.
  assign unused_tail = ^{stage_chain[NSTAGES-1].amt, stage_chain[NSTAGES-1].arith};

endmodule

// File: tb/tb_barrel_rshift32_pipe.sv
// Scoreboard bench for barrel_rshift32_pipe: directed vectors, hold freeze and mid-stream reset.
module tb_barrel_rshift32_pipe;

  typedef struct {
    logic [31:0] data;
    int          stamp;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   act = 0;
  int   last_act = 0;
  int   total_cnt = 0;
  int   pass_cnt = 0;
  exp_t sb_q[$];

  barrel_rshift32_pipe_if bus();

  barrel_rshift32_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counts clock edges on which the pipeline actually advanced.
  always @(posedge clk) begin
    if (rst_n && !bus.hold) act <= act + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total_cnt++;
    if (got !== req) begin
      $display("FAIL %s: got %h required %h", name, got, req);
    end else begin
      pass_cnt++;
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Monitor: one pop per freshly presented result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && act != last_act) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid: got out_data %h, required no output", bus.out_data);
      end else begin
        e = sb_q.pop_front();
        check({e.name, " data"}, bus.out_data, e.data);
        check({e.name, " latency"}, 32'(act - e.stamp), 32'd5);
      end
    end
    last_act = act;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] d, input logic [4:0] a, input logic ar,
                       input logic [31:0] expd, input string name);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_arith = ar;
    e.data  = expd;
    e.stamp = act;
    e.name  = name;
    sb_q.push_back(e);
    tick();
  endtask

  task automatic bubbles(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [31:0] vec_d   [10] = '{32'h80000000, 32'h80000000, 32'hF0F0F0F0, 32'hDEADBEEF, 32'hDEADBEEF,
                                32'h12345678, 32'h87654321, 32'h87654321, 32'h7FFFFFFF, 32'hC0000000};
  logic [4:0]  vec_a   [10] = '{5'd31, 5'd31, 5'd4, 5'd0, 5'd0, 5'd8, 5'd12, 5'd12, 5'd31, 5'd1};
  logic        vec_ar  [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] vec_exp [10] = '{32'h00000001, 32'hFFFFFFFF, 32'hFF0F0F0F, 32'hDEADBEEF, 32'hDEADBEEF,
                                32'h00123456, 32'hFFF87654, 32'h00087654, 32'h00000000, 32'hE0000000};

  initial begin
    logic [31:0] ones;
    rst_n        = 1'b0;
    bus.hold     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_amt   = '0;
    bus.in_arith = 1'b0;
    #1;
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset out_data", bus.out_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table, issued back-to-back
    for (int i = 0; i < 10; i++) issue(vec_d[i], vec_a[i], vec_ar[i], vec_exp[i], $sformatf("vec%0d", i));
    bubbles(6);

    // Single op: exactly one out_valid pulse
    issue(32'h80000000, 5'd31, 1'b0, 32'h00000001, "single");
    bubbles(8);

    // Full amount sweep on all-ones, logical
    ones = 32'hFFFFFFFF;
    for (int n = 0; n < 32; n++) issue(ones, 5'(n), 1'b0, ones >> n, $sformatf("sweep%0d", n));
    bubbles(6);

    // Hold for 3 cycles while the first of two results sits at the output
    issue(32'h12345678, 5'd4, 1'b0, 32'h01234567, "hold_op1");
    issue(32'h80000000, 5'd1, 1'b1, 32'hC0000000, "hold_op2");
    bubbles(3);
    bus.hold     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFFFFFF;
    bus.in_amt   = 5'd3;
    bus.in_arith = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("hold%0d out_data", i), bus.out_data, 32'h01234567);
    end
    bus.hold = 1'b0;
    bubbles(6);

    // Reset with three operations in flight
    bus.in_data  = 32'hA5A5A5A5;
    bus.in_amt   = 5'd0;
    bus.in_arith = 1'b0;
    bubbles(6);
    issue(32'h11111111, 5'd4, 1'b0, 32'h01111111, "doomed0");
    issue(32'h22222222, 5'd8, 1'b0, 32'h00222222, "doomed1");
    issue(32'h33333333, 5'd2, 1'b1, 32'h0CCCCCCC, "doomed2");
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midreset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midreset out_data", bus.out_data, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bubbles(10);

    // First op after reset release
    issue(32'h80000000, 5'd16, 1'b1, 32'hFFFF8000, "post_reset");
    bubbles(7);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
